// File: rtl/part_shift_ctl_pkg.sv
// Shared constants for the 74S194 chain sequencer.
// Optional feature macro: PART_SHIFT_CTL_ROTATE_EN (enables CMD_ROT rotate mode).
package part_shift_ctl_pkg;

  // Command op codes
  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_UP  = 2'b01;
  localparam logic [1:0] OP_DN  = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  // 194 mode select {S1,S0}
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACT  = 2'b01,
    FIN  = 2'b10
  } state_t;

`ifdef PART_SHIFT_CTL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

endpackage

// File: rtl/part_shift_shadow.sv
// Behavioural mirror of a chain of 74S194 parts; bit 0 = part 0 Q0.
module part_shift_shadow
  import part_shift_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S1,
  input  logic             S0,
  input  logic             SIR,
  input  logic             SIL,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] P_DATA,
  output logic [WIDTH-1:0] SHADOW
);

  // Chain update: clear dominates, then mode select
  always_ff @(posedge CLK) begin
    if (RESET || !CLR_N) begin
      SHADOW <= '0;
    end else begin
      case ({S1, S0})
        MODE_UP: SHADOW <= {SHADOW[WIDTH-2:0], SIR};
        MODE_DN: SHADOW <= {SIL, SHADOW[WIDTH-1:1]};
        MODE_LD: SHADOW <= P_DATA;
        default: SHADOW <= SHADOW;
      endcase
    end
  end

endmodule

// File: rtl/part_shift_ctl.sv
// Command sequencer for a WIDTH/4-part 74S194 chain with a cycle-exact shadow.
// Optional feature macro: PART_SHIFT_CTL_ROTATE_EN (CMD_ROT turns shifts into rotates).
module part_shift_ctl
  import part_shift_ctl_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [1:0]         CMD_OP,
  input  logic [COUNT_W-1:0] CMD_COUNT,
  input  logic               CMD_FILL,
  input  logic               CMD_ROT,
  input  logic [WIDTH-1:0]   CMD_DATA,
  output logic               S1,
  output logic               S0,
  output logic               SIR,
  output logic               SIL,
  output logic               CLR_N,
  output logic [WIDTH-1:0]   P_DATA,
  output logic [WIDTH-1:0]   SHADOW,
  output logic               DONE
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 fill_q, fill_d;
  logic                 rot_q, rot_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sir_q, sir_d;
  logic                 sil_q, sil_d;
  logic                 clr_n_q, clr_n_d;
  logic [WIDTH-1:0]     p_data_q, p_data_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 rot_req;

  // Rotate request only honoured when the feature is built in
  assign rot_req = CMD_ROT & ROT_EN;
  assign accept  = CMD_VALID & ready_q;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    fill_d   = fill_q;
    rot_d    = rot_q;
    mode_d   = MODE_HOLD;
    sir_d    = 1'b0;
    sil_d    = 1'b0;
    clr_n_d  = 1'b1;
    p_data_d = p_data_q;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
        if (accept) begin
          state_d = ACT;
          ready_d = 1'b0;
          op_d    = CMD_OP;
          cnt_d   = CMD_COUNT;
          fill_d  = CMD_FILL;
          rot_d   = rot_req;
          case (CMD_OP)
            OP_CLR: clr_n_d = 1'b0;
            OP_LD: begin
              mode_d   = MODE_LD;
              p_data_d = CMD_DATA;
            end
            default: begin
              if (CMD_COUNT == '0) begin
                // Nothing to shift: complete in the very next cycle
                state_d = FIN;
                done_d  = 1'b1;
                ready_d = 1'b1;
              end else if (CMD_OP == OP_UP) begin
                mode_d = MODE_UP;
                sir_d  = rot_req ? SHADOW[WIDTH-1] : CMD_FILL;
              end else begin
                mode_d = MODE_DN;
                sil_d  = rot_req ? SHADOW[0] : CMD_FILL;
              end
            end
          endcase
        end
      end
      ACT: begin
        if (op_q == OP_CLR || op_q == OP_LD || cnt_q <= COUNT_W'(1)) begin
          state_d = FIN;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          // Rotate taps the bit that will be at the far end after this edge's shift
          cnt_d = cnt_q - COUNT_W'(1);
          if (op_q == OP_UP) begin
            mode_d = MODE_UP;
            sir_d  = rot_q ? SHADOW[WIDTH-2] : fill_q;
          end else begin
            mode_d = MODE_DN;
            sil_d  = rot_q ? SHADOW[1] : fill_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_CLR;
      fill_q   <= 1'b0;
      rot_q    <= 1'b0;
      mode_q   <= MODE_HOLD;
      sir_q    <= 1'b0;
      sil_q    <= 1'b0;
      clr_n_q  <= 1'b0;
      p_data_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      rot_q    <= rot_d;
      mode_q   <= mode_d;
      sir_q    <= sir_d;
      sil_q    <= sil_d;
      clr_n_q  <= clr_n_d;
      p_data_q <= p_data_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign CMD_READY = ready_q;
  assign S1        = mode_q[1];
  assign S0        = mode_q[0];
  assign SIR       = sir_q;
  assign SIL       = sil_q;
  assign CLR_N     = clr_n_q;
  assign P_DATA    = p_data_q;
  assign DONE      = done_q;

  // Shadow follows the registered chain controls on the same edge as the chain
  part_shift_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .CLK    (CLK),
    .RESET  (RESET),
    .S1     (S1),
    .S0     (S0),
    .SIR    (SIR),
    .SIL    (SIL),
    .CLR_N  (CLR_N),
    .P_DATA (P_DATA),
    .SHADOW (SHADOW)
  );

endmodule

// File: tb/tb_part_shift_ctl.sv
// Self-checking bench for part_shift_ctl: command-level reference model plus a pin-driven chain.
module tb_part_shift_ctl;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned COUNT_W = 5;
  localparam logic [1:0] C_CLR = 2'b00, C_UP = 2'b01, C_DN = 2'b10, C_LD = 2'b11;
`ifdef PART_SHIFT_CTL_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               CMD_VALID = 1'b0;
  logic [1:0]         CMD_OP = 2'b00;
  logic [COUNT_W-1:0] CMD_COUNT = '0;
  logic               CMD_FILL = 1'b0;
  logic               CMD_ROT = 1'b0;
  logic [WIDTH-1:0]   CMD_DATA = '0;
  logic               CMD_READY, S1, S0, SIR, SIL, CLR_N, DONE;
  logic [WIDTH-1:0]   P_DATA, SHADOW;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] chain = '0;
  logic [WIDTH-1:0] model = '0;
  logic [WIDTH-1:0] last_load = '0;

  always #5 CLK = ~CLK;

  part_shift_ctl #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT), .CMD_FILL(CMD_FILL), .CMD_ROT(CMD_ROT),
    .CMD_DATA(CMD_DATA), .S1(S1), .S0(S0), .SIR(SIR), .SIL(SIL), .CLR_N(CLR_N),
    .P_DATA(P_DATA), .SHADOW(SHADOW), .DONE(DONE)
  );

  // Stand-in for the physical 194 chain, driven only by the DUT pins
  always @(posedge CLK) begin
    if (CLR_N === 1'b0) chain <= '0;
    else if (CLR_N === 1'b1) begin
      case ({S1, S0})
        2'b01: chain <= {chain[WIDTH-2:0], SIR};
        2'b10: chain <= {SIL, chain[WIDTH-1:1]};
        2'b11: chain <= P_DATA;
        default: ;
      endcase
    end
  end

  // Whole-command result computed with plain shift arithmetic
  function automatic logic [WIDTH-1:0] expect_cmd(input logic [1:0] op, input int n, input logic fill,
                                                   input logic rot, input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] ones;
    int k;
    ones = '1;
    if (op == C_CLR) return '0;
    if (op == C_LD) return d;
    if (rot && ROT_ON) begin
      k = n % WIDTH;
      if (k == 0) return cur;
      if (op == C_UP) return (cur << k) | (cur >> (WIDTH - k));
      return (cur >> k) | (cur << (WIDTH - k));
    end
    if (n >= WIDTH) return fill ? ones : '0;
    if (op == C_UP) return (cur << n) | (fill ? ~(ones << n) : '0);
    return (cur >> n) | (fill ? ~(ones >> n) : '0);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input int n);
    return (op == C_CLR || op == C_LD) ? 1 : n;
  endfunction

  function automatic int exp_modes(input logic [1:0] op, input int n);
    if (op == C_LD) return 1;
    if (op == C_CLR) return 0;
    return n;
  endfunction

  // Issue one command and observe it until DONE; measurement only
  task automatic run_cmd(input logic [1:0] op, input int n, input logic fill, input logic rot,
                         input logic [WIDTH-1:0] d, output int lat, output int modes,
                         output int clrs, output int bad, output int wt, output logic [1:0] lm,
                         output logic rdy, output bit to);
    lat = 0; modes = 0; clrs = 0; bad = 0; wt = 0; lm = 2'b00; rdy = 1'b0; to = 1'b0;
    while (CMD_READY !== 1'b1 && wt < 20) begin @(posedge CLK); #1; wt++; end
    if (wt >= 20) to = 1'b1;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_COUNT = COUNT_W'(n); CMD_FILL = fill;
    CMD_ROT = rot; CMD_DATA = d;
    @(posedge CLK); #1;
    forever begin
      if (DONE === 1'b1) begin rdy = CMD_READY; CMD_VALID = 1'b0; break; end
      if ({S1, S0} !== 2'b00) begin modes++; lm = {S1, S0}; end
      if (CLR_N === 1'b0) clrs++;
      if (({S1, S0} === 2'b01 && SIL !== 1'b0) || ({S1, S0} === 2'b10 && SIR !== 1'b0)) bad++;
      if (lat >= 40) begin to = 1'b1; CMD_VALID = 1'b0; break; end
      // Traffic while busy must be ignored
      CMD_VALID = 1'($urandom); CMD_OP = 2'($urandom); CMD_COUNT = COUNT_W'($urandom);
      CMD_FILL = 1'($urandom); CMD_ROT = 1'($urandom); CMD_DATA = WIDTH'($urandom);
      @(posedge CLK); #1; lat++;
    end
    model = expect_cmd(op, n, fill, rot, d, model);
    if (op == C_LD) last_load = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    checks++; if ({S1, S0, SIR, SIL, CLR_N, DONE, CMD_READY} !== 7'b0) begin failures++;
      $display("FAIL reset_ctrl: got %b want 0000000", {S1, S0, SIR, SIL, CLR_N, DONE, CMD_READY}); end
    checks++; if (P_DATA !== '0 || SHADOW !== '0) begin failures++;
      $display("FAIL reset_data: got p=%h s=%h want 0", P_DATA, SHADOW); end
    RESET = 1'b0;
    @(posedge CLK); #1;
    checks++; if (CLR_N !== 1'b1 || CMD_READY !== 1'b1 || DONE !== 1'b0) begin failures++;
      $display("FAIL release: got clr_n=%b ready=%b done=%b want 1 1 0", CLR_N, CMD_READY, DONE); end
    checks++; if (SHADOW !== 16'h0000 || chain !== 16'h0000) begin failures++;
      $display("FAIL release_chain: got s=%h c=%h want 0000", SHADOW, chain); end
    model = '0; last_load = '0;
  endtask

  task automatic test_load_shift_up();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'hA5C3, lat, modes, clrs, bad, wt, lm, rdy, to);
    checks++; if (lat !== 1 || to) begin failures++; $display("FAIL load_lat: got %0d want 1", lat); end
    checks++; if (SHADOW !== 16'hA5C3 || chain !== 16'hA5C3) begin failures++;
      $display("FAIL load_val: got s=%h c=%h want a5c3", SHADOW, chain); end
    run_cmd(C_UP, 4, 1'b1, 1'b0, 16'h0000, lat, modes, clrs, bad, wt, lm, rdy, to);
    checks++; if (lat !== 4 || modes !== 4 || to) begin failures++;
      $display("FAIL up4_timing: got lat=%0d modes=%0d want 4 4", lat, modes); end
    checks++; if (SHADOW !== 16'h5C3F || chain !== 16'h5C3F) begin failures++;
      $display("FAIL up4_val: got s=%h c=%h want 5c3f", SHADOW, chain); end
    checks++; if (bad !== 0 || rdy !== 1'b1) begin failures++;
      $display("FAIL up4_pins: got bad=%0d ready=%b want 0 1", bad, rdy); end
  endtask

  task automatic test_shift_down();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'h8001, lat, modes, clrs, bad, wt, lm, rdy, to);
    run_cmd(C_DN, 1, 1'b0, 1'b0, 16'h0000, lat, modes, clrs, bad, wt, lm, rdy, to);
    checks++; if (modes !== 1 || lm !== 2'b10 || lat !== 1) begin failures++;
      $display("FAIL dn1_mode: got modes=%0d mode=%b lat=%0d want 1 10 1", modes, lm, lat); end
    checks++; if (SHADOW !== 16'h4000 || chain !== 16'h4000) begin failures++;
      $display("FAIL dn1_val: got s=%h c=%h want 4000", SHADOW, chain); end
  endtask

  task automatic test_count_zero();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    run_cmd(C_UP, 0, 1'b1, 1'b0, 16'h0000, lat, modes, clrs, bad, wt, lm, rdy, to);
    checks++; if (lat !== 0 || modes !== 0 || rdy !== 1'b1 || to) begin failures++;
      $display("FAIL cnt0: got lat=%0d modes=%0d ready=%b want 0 0 1", lat, modes, rdy); end
    checks++; if (SHADOW !== 16'h4000 || chain !== 16'h4000) begin failures++;
      $display("FAIL cnt0_val: got s=%h c=%h want 4000", SHADOW, chain); end
  endtask

  task automatic test_rotate();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    logic [WIDTH-1:0] want;
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'h8001, lat, modes, clrs, bad, wt, lm, rdy, to);
    run_cmd(C_UP, 1, 1'b0, 1'b1, 16'h0000, lat, modes, clrs, bad, wt, lm, rdy, to);
    want = ROT_ON ? 16'h0003 : 16'h0002;
    checks++; if (SHADOW !== want || chain !== want) begin failures++;
      $display("FAIL rot_up: got s=%h c=%h want %h", SHADOW, chain, want); end
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'h8001, lat, modes, clrs, bad, wt, lm, rdy, to);
    run_cmd(C_DN, 1, 1'b0, 1'b1, 16'h0000, lat, modes, clrs, bad, wt, lm, rdy, to);
    want = ROT_ON ? 16'hC000 : 16'h4000;
    checks++; if (SHADOW !== want || chain !== want) begin failures++;
      $display("FAIL rot_dn: got s=%h c=%h want %h", SHADOW, chain, want); end
  endtask

  task automatic test_clear();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'hBEEF, lat, modes, clrs, bad, wt, lm, rdy, to);
    run_cmd(C_CLR, 7, 1'b1, 1'b0, 16'h1234, lat, modes, clrs, bad, wt, lm, rdy, to);
    checks++; if (clrs !== 1 || modes !== 0 || lat !== 1) begin failures++;
      $display("FAIL clr_timing: got clrs=%0d modes=%0d lat=%0d want 1 0 1", clrs, modes, lat); end
    checks++; if (SHADOW !== 16'h0000 || chain !== 16'h0000 || P_DATA !== 16'hBEEF) begin failures++;
      $display("FAIL clr_val: got s=%h c=%h p=%h want 0000 0000 beef", SHADOW, chain, P_DATA); end
  endtask

  task automatic test_back_to_back();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    logic [1:0] ops [4];
    int cnts [4];
    ops = '{C_LD, C_UP, C_DN, C_UP};
    cnts = '{0, 3, 2, 20};
    for (int i = 0; i < 4; i++) begin
      run_cmd(ops[i], cnts[i], 1'(i), 1'b0, 16'h1234, lat, modes, clrs, bad, wt, lm, rdy, to);
      checks++; if ((i > 0 && wt !== 0) || rdy !== 1'b1 || to) begin failures++;
        $display("FAIL b2b_%0d: got wait=%0d ready=%b want 0 1", i, wt, rdy); end
      checks++; if (SHADOW !== model || chain !== model) begin failures++;
        $display("FAIL b2b_val_%0d: got s=%h c=%h want %h", i, SHADOW, chain, model); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    int done_seen;
    run_cmd(C_LD, 0, 1'b0, 1'b0, 16'hFFFF, lat, modes, clrs, bad, wt, lm, rdy, to);
    CMD_VALID = 1'b1; CMD_OP = C_UP; CMD_COUNT = COUNT_W'(10); CMD_FILL = 1'b0; CMD_ROT = 1'b0;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    done_seen = 0;
    repeat (2) begin @(posedge CLK); #1; if (DONE === 1'b1) done_seen++; end
    checks++; if (SHADOW !== 16'hFFFC) begin failures++;
      $display("FAIL mid_progress: got %h want fffc", SHADOW); end
    RESET = 1'b1;
    repeat (2) begin @(posedge CLK); #1; if (DONE === 1'b1) done_seen++; end
    RESET = 1'b0;
    @(posedge CLK); #1;
    checks++; if (CMD_READY !== 1'b1 || CLR_N !== 1'b1 || P_DATA !== '0) begin failures++;
      $display("FAIL mid_release: got ready=%b clr_n=%b p=%h want 1 1 0000", CMD_READY, CLR_N, P_DATA); end
    checks++; if (SHADOW !== 16'h0000 || chain !== 16'h0000) begin failures++;
      $display("FAIL mid_chain: got s=%h c=%h want 0000", SHADOW, chain); end
    repeat (12) begin @(posedge CLK); #1; if (DONE === 1'b1) done_seen++; end
    checks++; if (done_seen !== 0) begin failures++;
      $display("FAIL mid_done: got %0d pulses want 0", done_seen); end
    model = '0; last_load = '0;
  endtask

  task automatic test_random();
    int lat, modes, clrs, bad, wt; logic [1:0] lm; logic rdy; bit to;
    logic [1:0] op; int n; logic fill, rot; logic [WIDTH-1:0] d;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 9));
      fill = 1'($urandom); rot = 1'($urandom); d = WIDTH'($urandom);
      run_cmd(op, n, fill, rot, d, lat, modes, clrs, bad, wt, lm, rdy, to);
      checks++; if (lat !== exp_lat(op, n) || modes !== exp_modes(op, n) || to) begin failures++;
        $display("FAIL rnd_timing_%0d: got lat=%0d modes=%0d want %0d %0d", i, lat, modes,
                 exp_lat(op, n), exp_modes(op, n)); end
      checks++; if (clrs !== ((op == C_CLR) ? 1 : 0) || bad !== 0 || rdy !== 1'b1) begin failures++;
        $display("FAIL rnd_pins_%0d: got clrs=%0d bad=%0d ready=%b", i, clrs, bad, rdy); end
      checks++; if (SHADOW !== model || chain !== model || P_DATA !== last_load) begin failures++;
        $display("FAIL rnd_val_%0d: got s=%h c=%h p=%h want %h p=%h", i, SHADOW, chain, P_DATA,
                 model, last_load); end
    end
  endtask

  initial begin
    test_reset();
    test_load_shift_up();
    test_shift_down();
    test_count_zero();
    test_rotate();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
